// File: rtl/alu_4bit_if.sv
// rtl/alu_4bit_if.sv - Operand/op request and registered result/flag bundle for alu_4bit
interface alu_4bit_if #(
  parameter int N = 4
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         in_valid;
  logic [N-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         out_valid;

  modport master (
    output a, b, op, in_valid,
    input  result, carry, overflow, zero, negative, out_valid
  );

  modport slave (
    input  a, b, op, in_valid,
    output result, carry, overflow, zero, negative, out_valid
  );
endinterface

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - Registered N-bit add/sub/OR/XOR unit with carry, overflow, zero, negative flags
module alu_4bit #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_4bit_if.slave  bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  logic [N:0]   sum_ext;
  logic [N-1:0] res_c;
  logic         carry_c;
  logic         ovf_c;

  always_comb begin
    sum_ext = '0;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
        res_c   = sum_ext[N-1:0];
        carry_c = sum_ext[N];
        ovf_c   = (bus.a[N-1] == bus.b[N-1]) && (res_c[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        // A + ~B + 1: the extended bit is the inverted borrow
        sum_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
        res_c   = sum_ext[N-1:0];
        carry_c = ~sum_ext[N];
        ovf_c   = (bus.a[N-1] != bus.b[N-1]) && (res_c[N-1] != bus.a[N-1]);
      end
      OP_OR: begin
        res_c = bus.a | bus.b;
      end
      default: begin
        res_c = bus.a ^ bus.b;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b1;
      bus.negative  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.result    <= res_c;
      bus.carry     <= carry_c;
      bus.overflow  <= ovf_c;
      bus.zero      <= (res_c == '0);
      bus.negative  <= res_c[N-1];
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// tb/tb_alu_4bit.sv - Self-checking bench for alu_4bit against an integer reference model
module tb_alu_4bit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  alu_4bit_if #(.N(4)) bus ();

  alu_4bit #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {result, carry, overflow, zero, negative} from plain integer arithmetic
  function automatic logic [7:0] model(input int a, input int b, input int op);
    int r, c, v, sa, sb, s;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 0;
    v = 0;
    case (op)
      0: begin
        r = (a + b) % 16;
        c = (a + b > 15) ? 1 : 0;
        s = sa + sb;
        v = (s > 7 || s < -8) ? 1 : 0;
      end
      2: begin
        r = (a - b + 16) % 16;
        c = (a < b) ? 1 : 0;
        s = sa - sb;
        v = (s > 7 || s < -8) ? 1 : 0;
      end
      1: r = a | b;
      default: r = a ^ b;
    endcase
    model = {r[3:0], c[0], v[0], (r == 0), (r >= 8)};
  endfunction

  function automatic logic [7:0] observed();
    observed = {bus.result, bus.carry, bus.overflow, bus.zero, bus.negative};
  endfunction

  task automatic drive_cycle(input logic r, input logic v, input logic [3:0] a,
                             input logic [3:0] b, input logic [1:0] op);
    rst = r;
    bus.in_valid = v;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 4'hF, 4'h1, 2'b00);
      tests++;
      if (observed() !== 8'b0000_0010) begin
        fails++;
        $display("FAIL reset_flags cycle %0d: got %b want %b", i, observed(), 8'b0000_0010);
      end
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_out_valid cycle %0d: got %b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_add();
    drive_cycle(1'b0, 1'b1, 4'b1111, 4'b0001, 2'b00);
    tests++;
    if ({bus.out_valid, observed()} !== {1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL add_wrap: got %b want %b", {bus.out_valid, observed()}, 9'b1_0000_1010);
    end
    drive_cycle(1'b0, 1'b1, 4'b0111, 4'b0001, 2'b00);
    tests++;
    if ({bus.out_valid, observed()} !== {1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL add_overflow: got %b want %b", {bus.out_valid, observed()}, 9'b1_1000_0101);
    end
  endtask

  task automatic test_sub();
    drive_cycle(1'b0, 1'b1, 4'b0011, 4'b0101, 2'b10);
    tests++;
    if (observed() !== {4'b1110, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL sub_borrow: got %b want %b", observed(), 8'b1110_1001);
    end
    drive_cycle(1'b0, 1'b1, 4'b1000, 4'b0001, 2'b10);
    tests++;
    if (observed() !== {4'b0111, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL sub_overflow: got %b want %b", observed(), 8'b0111_0100);
    end
  endtask

  task automatic test_logic();
    drive_cycle(1'b0, 1'b1, 4'b1010, 4'b0110, 2'b01);
    tests++;
    if (observed() !== {4'b1110, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL logic_or: got %b want %b", observed(), 8'b1110_0001);
    end
    drive_cycle(1'b0, 1'b1, 4'b1010, 4'b0110, 2'b11);
    tests++;
    if (observed() !== {4'b1100, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL logic_xor: got %b want %b", observed(), 8'b1100_0001);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b;
    logic [1:0] op;
    logic [7:0] exp_v;
    exp_v = '0;
    for (int i = 0; i < 3; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      op = 2'(i + 1);
      exp_v = model(int'(a), int'(b), int'(op));
      drive_cycle(1'b0, 1'b1, a, b, op);
      tests++;
      if ({bus.out_valid, observed()} !== {1'b1, exp_v}) begin
        fails++;
        $display("FAIL b2b_op%0d a=%h b=%h op=%0d: got %b want %b", i, a, b, op,
                 {bus.out_valid, observed()}, {1'b1, exp_v});
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00);
      tests++;
      if ({bus.out_valid, observed()} !== {1'b0, exp_v}) begin
        fails++;
        $display("FAIL hold_cycle%0d: got %b want %b", i, {bus.out_valid, observed()}, {1'b0, exp_v});
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive_cycle(1'b0, 1'b1, 4'h5, 4'h6, 2'b00);
    drive_cycle(1'b1, 1'b1, 4'h9, 4'h3, 2'b10);
    tests++;
    if ({bus.out_valid, observed()} !== 9'b0_0000_0010) begin
      fails++;
      $display("FAIL midstream_reset: got %b want %b", {bus.out_valid, observed()}, 9'b0_0000_0010);
    end
    drive_cycle(1'b0, 1'b1, 4'h9, 4'h3, 2'b10);
    tests++;
    if ({bus.out_valid, observed()} !== {1'b1, model(9, 3, 2)}) begin
      fails++;
      $display("FAIL first_after_reset: got %b want %b", {bus.out_valid, observed()}, {1'b1, model(9, 3, 2)});
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    logic [1:0] op;
    logic [7:0] exp_v;
    for (int i = 0; i < 100; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      exp_v = model(int'(a), int'(b), int'(op));
      drive_cycle(1'b0, 1'b1, a, b, op);
      tests++;
      if ({bus.out_valid, observed()} !== {1'b1, exp_v}) begin
        fails++;
        $display("FAIL random_%0d a=%h b=%h op=%0d: got %b want %b", i, a, b, op,
                 {bus.out_valid, observed()}, {1'b1, exp_v});
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
